// File: rtl/sr_pkg.sv
// Shared types and constants for the 595 display scanner.
package sr_pkg;

   // Scanner phases, one pass per digit.
   typedef enum logic [2:0] {
      BLANK     = 3'd0,
      SEND      = 3'd1,
      WAIT_BUSY = 3'd2,
      WAIT_DONE = 3'd3,
      DWELL     = 3'd4
   } sr_state_t;

   // Cycles to wait for the driver to drop ready before moving on anyway.
   localparam int SR_ACK_TIMEOUT = 16;

   // Digit enable levels for an active-low digit bank; inverted when active-high.
   localparam logic DIG_OFF_AL = 1'b1;
   localparam logic DIG_ON_AL  = 1'b0;

endpackage

// File: rtl/sr_display_scanner.sv
// Time-multiplexes a bank of segment bytes onto one 74hc595 segment driver
// and drives the digit-select lines directly.
module sr_display_scanner
   import sr_pkg::*;
#(
   parameter int NUM_DIGITS       = 4,
   parameter int DWELL_CYCLES     = 50000,
   parameter int BLANK_CYCLES     = 16,
   parameter bit DIGIT_ACTIVE_LOW = 1'b1,
   localparam int AW              = $clog2(NUM_DIGITS)
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_wr_en,
   input  logic [AW-1:0]         i_wr_addr,
   input  logic [7:0]            i_wr_data,
   input  logic                  i_blank,
   input  logic                  i_sr_ready,
   output logic [7:0]            o_sr_data,
   output logic                  o_sr_enable,
   output logic [NUM_DIGITS-1:0] o_digit,
   output logic [AW-1:0]         o_scan_idx
);

   // One counter serves BLANK, DWELL and the handshake timeout.
   localparam int MAXC0 = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int MAXC  = (MAXC0 > SR_ACK_TIMEOUT) ? MAXC0 : SR_ACK_TIMEOUT;
   localparam int CW    = $clog2(MAXC + 1);

   localparam logic DIG_OFF = DIGIT_ACTIVE_LOW ? DIG_OFF_AL : ~DIG_OFF_AL;
   localparam logic DIG_ON  = DIGIT_ACTIVE_LOW ? DIG_ON_AL  : ~DIG_ON_AL;
   localparam logic [NUM_DIGITS-1:0] ALL_OFF = {NUM_DIGITS{DIG_OFF}};
   localparam logic [AW:0]   NUM_D    = (AW+1)'(NUM_DIGITS);
   localparam logic [AW-1:0] LAST_IDX = AW'(NUM_DIGITS - 1);

   sr_state_t             state, state_n;
   logic [CW-1:0]         cnt, cnt_n;
   logic [AW-1:0]         idx, idx_n;
   logic                  en_n;
   logic [7:0]            data_n;
   logic [NUM_DIGITS-1:0] digit_n;
   logic [7:0]            bank [NUM_DIGITS];

   // Host write port into the segment bank; out-of-range addresses dropped.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int d = 0; d < NUM_DIGITS; d++) bank[d] <= 8'h00;
      end else if (i_wr_en && ({1'b0, i_wr_addr} < NUM_D)) begin
         bank[i_wr_addr] <= i_wr_data;
      end
   end

   // State and registered outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= BLANK;
         cnt         <= '0;
         idx         <= '0;
         o_sr_enable <= 1'b0;
         o_sr_data   <= 8'h00;
         o_digit     <= ALL_OFF;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         idx         <= idx_n;
         o_sr_enable <= en_n;
         o_sr_data   <= data_n;
         o_digit     <= digit_n;
      end
   end

   // Next-state logic; digit enables follow the next state so the digit is
   // lit exactly while the FSM sits in DWELL.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      en_n    = 1'b0;
      data_n  = o_sr_data;
      digit_n = ALL_OFF;
      case (state)
         BLANK: begin
            if (cnt == CW'(BLANK_CYCLES - 1)) begin
               state_n = SEND;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         SEND: begin
            // Driver has no reset, so never launch until it reports ready.
            if (i_sr_ready) begin
               en_n    = 1'b1;
               data_n  = bank[idx];
               state_n = WAIT_BUSY;
               cnt_n   = '0;
            end
         end
         WAIT_BUSY: begin
            if (!i_sr_ready || cnt == CW'(SR_ACK_TIMEOUT - 1)) begin
               state_n = WAIT_DONE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         WAIT_DONE: begin
            if (i_sr_ready) begin
               state_n = DWELL;
               cnt_n   = '0;
            end
         end
         DWELL: begin
            if (cnt == CW'(DWELL_CYCLES - 1)) begin
               state_n = BLANK;
               cnt_n   = '0;
               idx_n   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: begin
            state_n = BLANK;
            cnt_n   = '0;
         end
      endcase
      if (state_n == DWELL && !i_blank) begin
         for (int d = 0; d < NUM_DIGITS; d++)
            if (idx_n == AW'(d)) digit_n[d] = DIG_ON;
      end
   end

   assign o_scan_idx = idx;

endmodule

// File: tb/tb_sr_display_scanner.sv
// Directed bench for sr_display_scanner with a behavioural 595 driver model.
module tb_sr_display_scanner;

   localparam int ND = 4;
   localparam int DW = 20;
   localparam int BL = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_en = 1'b0;
   logic [1:0] wr_addr = '0;
   logic [7:0] wr_data = '0;
   logic       blank = 1'b0;
   logic       sr_ready;
   logic [7:0] sr_data;
   logic       sr_enable;
   logic [3:0] digit;
   logic [1:0] scan_idx;

   int checks = 0;
   int errors = 0;

   sr_display_scanner #(
      .NUM_DIGITS(ND), .DWELL_CYCLES(DW), .BLANK_CYCLES(BL), .DIGIT_ACTIVE_LOW(1'b1)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
      .i_wr_data(wr_data), .i_blank(blank), .i_sr_ready(sr_ready),
      .o_sr_data(sr_data), .o_sr_enable(sr_enable), .o_digit(digit),
      .o_scan_idx(scan_idx)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // 595 driver model: ready drops the cycle after enable, busy 40 cycles,
   // byte recorded as latched when ready returns. In stuck mode it accepts
   // and latches at once without ever dropping ready.
   logic       m_ready = 1'b1;
   int         busy = 0;
   bit         force_low = 1'b0;
   bit         stuck = 1'b0;
   logic [7:0] shreg = '0;
   logic [7:0] latched[$];

   assign sr_ready = m_ready & ~force_low;

   always @(posedge clk) begin
      if (busy > 0) begin
         busy <= busy - 1;
         if (busy == 1) begin
            m_ready <= 1'b1;
            latched.push_back(shreg);
         end
      end else if (sr_enable && sr_ready) begin
         shreg <= sr_data;
         if (stuck) latched.push_back(sr_data);
         else begin
            m_ready <= 1'b0;
            busy    <= 40;
         end
      end
   end

   // Protocol monitor and lit-run recorder.
   typedef struct {logic [3:0] pat; int len;} run_t;
   run_t       runs[$];
   bit         prev_en = 1'b0;
   logic [3:0] prev_dig = 4'hF;
   int         run = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_en  = 1'b0;
         prev_dig = 4'hF;
         run      = 0;
      end else begin
         if (sr_enable) begin
            chk("en_single_cycle", int'(prev_en), 0);
            chk("en_while_ready", int'(sr_ready), 1);
         end
         if (!m_ready && busy > 0) chk("dark_during_shift", int'(digit), 'hF);
         if (digit != 4'hF) begin
            run = (digit == prev_dig) ? run + 1 : 1;
         end else if (prev_dig != 4'hF) begin
            runs.push_back('{prev_dig, run});
         end
         prev_dig = digit;
         prev_en  = sr_enable;
      end
   end

   typedef struct {
      logic [1:0] addr;
      logic [7:0] data;
      logic [7:0] exp_latch;
      logic [3:0] exp_dig;
      int         exp_len;
   } vec_t;
   vec_t vecs[5];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected to end on its own");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad, n, pulses;
      bit ok;
      vecs[0] = '{2'd0, 8'h3F, 8'h3F, 4'b1110, DW};
      vecs[1] = '{2'd1, 8'h06, 8'h06, 4'b1101, DW};
      vecs[2] = '{2'd2, 8'h5B, 8'h5B, 4'b1011, DW};
      vecs[3] = '{2'd3, 8'h4F, 8'h4F, 4'b0111, DW};
      vecs[4] = '{2'd0, 8'h3F, 8'h3F, 4'b1110, DW};

      // Reset values, sampled between edges.
      #12;
      chk("rst_digit", int'(digit), 'hF);
      chk("rst_enable", int'(sr_enable), 0);
      chk("rst_data", int'(sr_data), 0);
      chk("rst_idx", int'(scan_idx), 0);

      // Release with driver holding ready low; load the bank meanwhile.
      @(negedge clk);
      rst_n = 1'b1;
      force_low = 1'b1;
      bad = 0;
      for (int c = 0; c < 100; c++) begin
         if (c < 4) begin
            wr_en = 1'b1; wr_addr = vecs[c].addr; wr_data = vecs[c].data;
         end else wr_en = 1'b0;
         @(negedge clk);
         if (sr_enable) bad++;
      end
      wr_en = 1'b0;
      chk("hold_low_no_enable", bad, 0);
      latched.delete();
      runs.delete();
      force_low = 1'b0;
      chk("enable_before_ready_edge", int'(sr_enable), 0);
      @(negedge clk);
      chk("first_enable_one_cycle_after_ready", int'(sr_enable), 1);
      chk("first_data", int'(sr_data), 'h3F);

      // Full scan: five latches and five lit runs.
      ok = 1'b0;
      for (int c = 0; c < 1000 && !ok; c++) begin
         @(negedge clk);
         ok = (latched.size() >= 5) && (runs.size() >= 5);
      end
      chk("scan_complete", int'(ok), 1);
      if (ok) begin
         for (int i = 0; i < 5; i++) begin
            chk($sformatf("latch[%0d]", i), int'(latched[i]), int'(vecs[i].exp_latch));
            chk($sformatf("digit[%0d]", i), int'(runs[i].pat), int'(vecs[i].exp_dig));
            chk($sformatf("lit_len[%0d]", i), runs[i].len, vecs[i].exp_len);
         end
      end

      // Write idx2 in the very cycle its SEND fires.
      n = 0;
      while (scan_idx == 2'd2 && n < 500) begin @(negedge clk); n++; end
      while (scan_idx != 2'd2 && n < 500) begin @(negedge clk); n++; end
      chk("reach_idx2", int'(n < 500), 1);
      latched.delete();
      @(negedge clk);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'hFF;
      @(negedge clk);
      wr_en = 1'b0;
      chk("collide_send_fired", int'(sr_enable), 1);
      chk("collide_send_data", int'(sr_data), 'h5B);
      ok = 1'b0;
      for (int c = 0; c < 800 && !ok; c++) begin
         @(negedge clk);
         ok = latched.size() >= 5;
      end
      chk("collide_scan_complete", int'(ok), 1);
      if (ok) begin
         chk("collide_old_value", int'(latched[0]), 'h5B);
         chk("collide_next_idx3", int'(latched[1]), 'h4F);
         chk("collide_new_value", int'(latched[4]), 'hFF);
      end

      // Blank during DWELL of idx1.
      n = 0;
      while (digit != 4'b1101 && n < 500) begin @(negedge clk); n++; end
      chk("reach_idx1_lit", int'(n < 500), 1);
      blank = 1'b1;
      bad = 0; pulses = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (digit != 4'hF) bad++;
         if (sr_enable) pulses++;
      end
      blank = 1'b0;
      chk("blank_dark", bad, 0);
      chk("blank_handshake_continues", pulses, 1);
      chk("blank_idx_advances", int'(scan_idx), 2);
      n = 0;
      while (digit != 4'b1011 && n < 200) begin @(negedge clk); n++; end
      chk("reach_idx2_lit", int'(n < 200), 1);
      blank = 1'b1;
      @(negedge clk);
      chk("blank_next_clock", int'(digit), 'hF);
      blank = 1'b0;
      @(negedge clk);
      chk("unblank_next_clock", int'(digit), 'b1011);

      // Asynchronous reset while waiting for the driver to finish.
      n = 0;
      while (!(m_ready == 1'b0 && busy > 0 && busy < 35 && scan_idx != 2'd0) && n < 500) begin
         @(negedge clk); n++;
      end
      chk("reach_wait_done", int'(n < 500), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_digit", int'(digit), 'hF);
      chk("midrst_enable", int'(sr_enable), 0);
      chk("midrst_data", int'(sr_data), 0);
      chk("midrst_idx", int'(scan_idx), 0);
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      while (!sr_enable && n < 200) begin @(negedge clk); n++; end
      chk("post_reset_send", int'(sr_enable), 1);
      chk("post_reset_idx", int'(scan_idx), 0);
      chk("post_reset_bank_cleared", int'(sr_data), 0);

      // Driver that never drops ready: WAIT_BUSY times out after 16 cycles.
      n = 0;
      while (digit == 4'hF && n < 200) begin @(negedge clk); n++; end
      chk("reach_idx0_lit", int'(n < 200), 1);
      stuck = 1'b1;
      latched.delete();
      wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h77;
      @(negedge clk);
      wr_en = 1'b0;
      n = 0;
      while (!sr_enable && n < 200) begin @(negedge clk); n++; end
      chk("stuck_send", int'(sr_enable), 1);
      chk("stuck_send_idx", int'(scan_idx), 1);
      n = 0;
      while (digit == 4'hF && n < 100) begin @(negedge clk); n++; end
      chk("stuck_timeout_latency", n, 17);
      chk("stuck_digit", int'(digit), 'b1101);
      chk("stuck_latched", int'(latched.size() > 0 ? latched[0] : 8'h00), 'h77);
      n = 0;
      while (!sr_enable && n < 200) begin @(negedge clk); n++; end
      chk("stuck_scan_continues", int'(scan_idx), 2);
      @(negedge clk);
      chk("stuck_enable_single", int'(sr_enable), 0);
      stuck = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
